rf_scoreboard: RTL and testbench

Dual-write, quad-read integer register file with per-register pending-write scoreboard, directly downstream of the writeback stage.
- Consumes ws_to_rf_bus, two lanes per cycle.
- Serves four decode-stage operand reads with same-cycle write-through bypass.
- Tracks in-flight destination reservations so issue logic can stall on RAW hazards.

---
 rtl/rf_scoreboard_pkg.sv | 33 +++
 rtl/rf_scoreboard_if.sv | 33 +++
 rtl/rf_pend_cnt.sv | 60 ++++++
 rtl/rf_scoreboard.sv | 113 +++++++++++
 tb/tb_rf_scoreboard.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_scoreboard_pkg.sv
// rf_scoreboard_pkg
// Shared constants and types for the dual-write / quad-read register file:
// writeback bus geometry, lane layout and a lane-hit helper.
package rf_scoreboard_pkg;

    localparam int WS_TO_RF_BUS_WD = 140;
    localparam int WB_LANE_WD      = 70;
    localparam int WB_PC_LSB       = 38;
    localparam int WB_WE_BIT       = 37;
    localparam int WB_ADDR_LSB     = 32;

    localparam int RF_NREG  = 32;
    localparam int RF_CNT_W = 2;
    localparam int RF_NRD   = 4;
    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;

    // Field order matches the lane layout: pc[69:38] we[37] waddr[36:32] wdata[31:0].
    typedef struct packed {
        logic [RF_DW-1:0] pc;
        logic             we;
        logic [RF_AW-1:0] waddr;
        logic [RF_DW-1:0] wdata;
    } wb_lane_t;

    // Number of writeback lanes (0..2) targeting address a this cycle.
    function automatic logic [1:0] wb_hits(input logic [RF_AW-1:0] a,
                                           input wb_lane_t l1,
                                           input wb_lane_t l2);
        return {1'b0, (l1.we && (l1.waddr == a))} + {1'b0, (l2.we && (l2.waddr == a))};
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// rf_scoreboard_if
// Bundles the writeback bus, issue-side reservations, flush and the four
// decode read ports. master = pipeline side, slave = register file.
//   ws_to_rf_bus : two writeback lanes (lane1 high half, lane2 low half)
//   flush        : clear all pending counters
//   rsv_we*/rsv_addr* : issue-lane destination reservations
//   raddr[k] / rdata[k] / rbusy[k] : read port k (k = 0..3)
//   cnt_err      : sticky pending-counter error
interface rf_scoreboard_if;
    import rf_scoreboard_pkg::*;

    logic [WS_TO_RF_BUS_WD-1:0]      ws_to_rf_bus;
    logic                            flush;
    logic                            rsv_we1;
    logic [RF_AW-1:0]                rsv_addr1;
    logic                            rsv_we2;
    logic [RF_AW-1:0]                rsv_addr2;
    logic [RF_NRD-1:0][RF_AW-1:0]    raddr;
    logic [RF_NRD-1:0][RF_DW-1:0]    rdata;
    logic [RF_NRD-1:0]               rbusy;
    logic                            cnt_err;

    modport master (
        output ws_to_rf_bus, flush, rsv_we1, rsv_addr1, rsv_we2, rsv_addr2, raddr,
        input  rdata, rbusy, cnt_err
    );

    modport slave (
        input  ws_to_rf_bus, flush, rsv_we1, rsv_addr1, rsv_we2, rsv_addr2, raddr,
        output rdata, rbusy, cnt_err
    );

endinterface

// File: rtl/rf_pend_cnt.sv
// rf_pend_cnt
// Pending-write counter for one architectural register.
//   clk, reset : clock, synchronous active-high reset
//   flush      : counter goes to 0 next cycle, reserves discarded
//   flush_d    : flush was asserted last cycle
//   inc, dec   : reserves / writebacks for this register this cycle (0..2)
//   cnt        : current pending count
//   err        : sticky over/underflow flag
module rf_pend_cnt
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = RF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             flush_d,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    localparam int SW = CNT_W + 3;
    localparam logic signed [SW-1:0] CNT_MAX = SW'((1 << CNT_W) - 1);

    logic [1:0]           inc_eff;
    logic [1:0]           dec_eff;
    logic signed [SW-1:0] sum;
    logic                 under;
    logic                 over;

    always_comb begin
        inc_eff = flush ? 2'd0 : inc;
        // Writebacks for reservations that a flush just dropped are not errors.
        dec_eff = (flush_d && (cnt == '0)) ? 2'd0 : dec;
        sum     = $signed(SW'(cnt)) + $signed(SW'(inc_eff)) - $signed(SW'(dec_eff));
        under   = sum[SW-1];
        over    = !sum[SW-1] && (sum > CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (flush || under) begin
                cnt <= '0;
            end else if (over) begin
                cnt <= CNT_MAX[CNT_W-1:0];
            end else begin
                cnt <= sum[CNT_W-1:0];
            end
            if (under || over) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Dual-write, quad-read integer register file with a per-register
// pending-write scoreboard, sitting right after writeback.
//   clk, reset : clock, synchronous active-high reset
//   rf (slave) : writeback bus, reservations, flush, 4 read ports, cnt_err
// Reads bypass same-cycle writebacks (lane2 over lane1 over storage);
// r0 reads zero and is never busy.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG  = RF_NREG,
    parameter int CNT_W = RF_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    rf_scoreboard_if.slave rf
);

    wb_lane_t lane1;
    wb_lane_t lane2;
    wb_lane_t wl1;
    wb_lane_t wl2;
    logic     unused_pc;

    assign lane1     = rf.ws_to_rf_bus[WS_TO_RF_BUS_WD-1:WB_LANE_WD];
    assign lane2     = rf.ws_to_rf_bus[WB_LANE_WD-1:0];
    assign unused_pc = ^{lane1.pc, lane2.pc};

    // Bus is ignored while reset is held, including the bypass path.
    always_comb begin
        wl1    = lane1;
        wl2    = lane2;
        wl1.we = lane1.we && !reset;
        wl2.we = lane2.we && !reset;
    end

    logic [RF_DW-1:0] regs [NREG];

    // Lane2 is program-later, so its write is placed last to win on a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wl1.we && (wl1.waddr != '0)) begin
                regs[wl1.waddr] <= wl1.wdata;
            end
            if (wl2.we && (wl2.waddr != '0)) begin
                regs[wl2.waddr] <= wl2.wdata;
            end
        end
    end

    logic flush_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_d <= 1'b0;
        end else begin
            flush_d <= rf.flush;
        end
    end

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            err;

    assign cnt[0] = '0;
    assign err[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cnt
        logic [1:0] inc;
        logic [1:0] dec;

        assign inc = {1'b0, (rf.rsv_we1 && (rf.rsv_addr1 == RF_AW'(i)))}
                   + {1'b0, (rf.rsv_we2 && (rf.rsv_addr2 == RF_AW'(i)))};
        assign dec = wb_hits(RF_AW'(i), wl1, wl2);

        rf_pend_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .flush   (rf.flush),
            .flush_d (flush_d),
            .inc     (inc),
            .dec     (dec),
            .cnt     (cnt[i]),
            .err     (err[i])
        );
    end

    assign rf.cnt_err = |err;

    // Busy compares against the writes landing now, so a final writeback
    // reads as free and bypassed. A write with nothing pending never
    // shows busy.
    always_comb begin
        for (int k = 0; k < RF_NRD; k++) begin
            rf.rdata[k] = '0;
            rf.rbusy[k] = 1'b0;
            if (rf.raddr[k] != '0) begin
                if (wl2.we && (wl2.waddr == rf.raddr[k])) begin
                    rf.rdata[k] = wl2.wdata;
                end else if (wl1.we && (wl1.waddr == rf.raddr[k])) begin
                    rf.rdata[k] = wl1.wdata;
                end else begin
                    rf.rdata[k] = regs[rf.raddr[k]];
                end
                rf.rbusy[k] = int'(cnt[rf.raddr[k]]) > int'(wb_hits(rf.raddr[k], wl1, wl2));
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_scoreboard_if rf();

    rf_scoreboard dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                         input logic we2, input logic [4:0] a2, input logic [31:0] d2,
                         input logic rw1, input logic [4:0] ra1,
                         input logic rw2, input logic [4:0] ra2,
                         input logic fl);
        logic [31:0] pc1;
        logic [31:0] pc2;
        pc1 = $urandom;
        pc2 = $urandom;
        rf.ws_to_rf_bus = {pc1, we1, a1, d1, pc2, we2, a2, d2};
        rf.flush     = fl;
        rf.rsv_we1   = rw1;
        rf.rsv_addr1 = ra1;
        rf.rsv_we2   = rw2;
        rf.rsv_addr2 = ra2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [4:0] a3);
        rf.raddr[0] = a0;
        rf.raddr[1] = a1;
        rf.raddr[2] = a2;
        rf.raddr[3] = a3;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input int k, input logic [31:0] rd, input logic bz);
        chk($sformatf("%s_rdata%0d", tag, k), rf.rdata[k], rd);
        chk($sformatf("%s_rbusy%0d", tag, k), 32'(rf.rbusy[k]), 32'(bz));
    endtask

    typedef struct {
        logic        we1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        we2;
        logic [4:0]  a2;
        logic [31:0] d2;
        logic        rw1;
        logic [4:0]  ra1;
        logic        rw2;
        logic [4:0]  ra2;
        logic        fl;
        logic [4:0]  ra;
        logic [31:0] rd;
        logic        bz;
        logic        er;
    } vec_t;

    function automatic vec_t mkv(int we1, int a1, int d1, int we2, int a2, int d2,
                                 int rw1, int ra1, int rw2, int ra2, int fl,
                                 int ra, int rd, int bz, int er);
        vec_t v;
        v.we1 = 1'(we1); v.a1 = 5'(a1); v.d1 = 32'(d1);
        v.we2 = 1'(we2); v.a2 = 5'(a2); v.d2 = 32'(d2);
        v.rw1 = 1'(rw1); v.ra1 = 5'(ra1);
        v.rw2 = 1'(rw2); v.ra2 = 5'(ra2);
        v.fl  = 1'(fl);  v.ra  = 5'(ra);
        v.rd  = 32'(rd); v.bz  = 1'(bz); v.er = 1'(er);
        return v;
    endfunction

    vec_t tbl[$];

    // Reference model state for the random phase.
    int          pend [32];
    logic [31:0] mreg [32];
    logic        merr;
    logic        mfl_d;

    initial begin
        vec_t v;

        //            we1 a1 d1            we2 a2 d2            rw1 ra1 rw2 ra2 fl  ra  rd            bz er
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  5, 0,            0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           1, 3, 1, 3, 0,  3, 0,            0, 0));
        tbl.push_back(mkv(1, 3, 'h11111111,  1, 3, 'h22222222,  0, 0, 0, 0, 0,  3, 'h22222222,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  3, 'h22222222,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           1, 7, 0, 0, 0,  7, 0,            0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  7, 0,            1, 0));
        tbl.push_back(mkv(0, 0, 0,           1, 7, 'hDEADBEEF,  0, 0, 0, 0, 0,  7, 'hDEADBEEF,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  7, 'hDEADBEEF,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           1, 9, 1, 9, 0,  9, 0,            0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  9, 0,            1, 0));
        tbl.push_back(mkv(1, 9, 'h0000000A,  0, 0, 0,           0, 0, 0, 0, 0,  9, 'h0000000A,   1, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  9, 'h0000000A,   1, 0));
        tbl.push_back(mkv(0, 0, 0,           1, 9, 'h0000000B,  0, 0, 0, 0, 0,  9, 'h0000000B,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  9, 'h0000000B,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           1, 4, 0, 0, 0,  4, 0,            0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 1, 4, 1,  4, 0,            1, 0));
        tbl.push_back(mkv(1, 4, 'h00000044,  0, 0, 0,           0, 0, 0, 0, 0,  4, 'h00000044,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  4, 'h00000044,   0, 0));
        tbl.push_back(mkv(1, 12, 'h0000000C, 0, 0, 0,           0, 0, 0, 0, 0, 12, 'h0000000C,   0, 0));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0, 12, 'h0000000C,   0, 1));
        tbl.push_back(mkv(1, 0, 'hFFFFFFFF,  1, 0, 'hFFFFFFFF,  0, 0, 0, 0, 0,  0, 0,            0, 1));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  0, 0,            0, 1));
        tbl.push_back(mkv(0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0,  3, 'h22222222,   0, 1));

        reset = 1'b1;
        idle();
        set_raddr(5'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            drive(v.we1, v.a1, v.d1, v.we2, v.a2, v.d2, v.rw1, v.ra1, v.rw2, v.ra2, v.fl);
            set_raddr(v.ra, v.ra, v.ra, v.ra);
            #2;
            for (int k = 0; k < RF_NRD; k++) begin
                chk_port($sformatf("row%0d", i), k, v.rd, v.bz);
            end
            chk($sformatf("row%0d_cnt_err", i), 32'(rf.cnt_err), 32'(v.er));
            cyc();
        end

        // Reset with active bus: everything ignored, sticky error cleared
        reset = 1'b1;
        drive(1'b1, 5'd5, 32'h55555555, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        set_raddr(5'd5, 5'd12, 5'd3, 5'd9);
        #2;
        chk("rst_bypass_gated", rf.rdata[0], 32'd0);
        cyc();
        reset = 1'b0;
        idle();
        #2;
        chk_port("post_rst", 0, 32'd0, 1'b0);
        chk_port("post_rst", 1, 32'd0, 1'b0);
        chk_port("post_rst", 2, 32'd0, 1'b0);
        chk_port("post_rst", 3, 32'd0, 1'b0);
        chk("post_rst_cnt_err", 32'(rf.cnt_err), 32'd0);
        cyc();

        // Overflow: four reserves on a 2-bit counter saturate at 3
        set_raddr(5'd20, 5'd20, 5'd0, 5'd21);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b1, 5'd20, 1'b0);
        #2; chk_port("ovf_a", 0, 32'd0, 1'b0);
        cyc();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b1, 5'd20, 1'b0);
        #2; chk_port("ovf_b", 0, 32'd0, 1'b1); chk("ovf_b_cnt_err", 32'(rf.cnt_err), 32'd0);
        cyc();
        idle();
        #2; chk_port("ovf_c", 0, 32'd0, 1'b1); chk("ovf_c_cnt_err", 32'(rf.cnt_err), 32'd1);
        chk_port("ovf_c", 3, 32'd0, 1'b0);
        cyc();
        drive(1'b1, 5'd20, 32'h000000D1, 1'b1, 5'd20, 32'h000000D2, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #2; chk_port("ovf_d", 0, 32'h000000D2, 1'b1);
        cyc();
        drive(1'b1, 5'd20, 32'h000000D3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        #2; chk_port("ovf_e", 0, 32'h000000D3, 1'b0);
        cyc();
        idle();
        #2; chk_port("ovf_f", 1, 32'h000000D3, 1'b0); chk("ovf_f_cnt_err", 32'(rf.cnt_err), 32'd1);
        cyc();

        // Random phase against the reference model
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            pend[r] = 0;
            mreg[r] = 32'd0;
        end
        merr  = 1'b0;
        mfl_d = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            int          left [32];
            int          cand [$];
            int          resv [32];
            logic        we1, we2, rw1, rw2, fl;
            logic [4:0]  a1, a2, ra1, ra2;
            logic [31:0] d1, d2;
            logic [4:0]  rdq [4];

            for (int r = 0; r < 32; r++) begin
                left[r] = pend[r];
                resv[r] = 0;
            end
            fl = ($urandom_range(0, 15) == 0);

            // Writebacks only retire outstanding reservations (or hit r0).
            we1 = 1'b0; a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
            cand.delete();
            for (int r = 1; r < 32; r++) if (left[r] > 0) cand.push_back(r);
            if ($urandom_range(0, 3) != 0 && cand.size() > 0) begin
                a1 = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                we1 = 1'b1;
                left[a1]--;
            end else if ($urandom_range(0, 3) == 0) begin
                a1 = 5'd0;
                we1 = 1'b1;
            end
            we2 = 1'b0; a2 = 5'($urandom_range(0, 31)); d2 = $urandom;
            cand.delete();
            for (int r = 1; r < 32; r++) if (left[r] > 0) cand.push_back(r);
            if ($urandom_range(0, 3) != 0 && cand.size() > 0) begin
                a2 = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                we2 = 1'b1;
                left[a2]--;
            end else if ($urandom_range(0, 3) == 0) begin
                a2 = 5'd0;
                we2 = 1'b1;
            end

            // Reserves kept within counter range.
            ra1 = 5'($urandom_range(0, 31));
            rw1 = 1'($urandom_range(0, 1));
            if (rw1 && pend[ra1] + 1 > 3) rw1 = 1'b0;
            if (rw1) resv[ra1]++;
            ra2 = 5'($urandom_range(0, 31));
            rw2 = 1'($urandom_range(0, 1));
            if (rw2 && pend[ra2] + resv[ra2] + 1 > 3) rw2 = 1'b0;

            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: rdq[k] = a1;
                    1: rdq[k] = a2;
                    default: rdq[k] = 5'($urandom_range(0, 31));
                endcase
            end

            drive(we1, a1, d1, we2, a2, d2, rw1, ra1, rw2, ra2, fl);
            set_raddr(rdq[0], rdq[1], rdq[2], rdq[3]);
            #2;
            for (int k = 0; k < 4; k++) begin
                logic [31:0] e_rd;
                int          w;
                if (rdq[k] == 5'd0) e_rd = 32'd0;
                else if (we2 && a2 == rdq[k]) e_rd = d2;
                else if (we1 && a1 == rdq[k]) e_rd = d1;
                else e_rd = mreg[rdq[k]];
                w = ((we1 && a1 == rdq[k]) ? 1 : 0) + ((we2 && a2 == rdq[k]) ? 1 : 0);
                chk_port($sformatf("rand%0d", n), k, e_rd,
                         (rdq[k] != 5'd0) && (pend[rdq[k]] > w));
            end
            chk($sformatf("rand%0d_cnt_err", n), 32'(rf.cnt_err), 32'(merr));
            cyc();

            // Model update
            if (we1 && a1 != 5'd0) mreg[a1] = d1;
            if (we2 && a2 != 5'd0) mreg[a2] = d2;
            for (int r = 1; r < 32; r++) begin
                int w, inc, nv;
                w   = ((we1 && a1 == r) ? 1 : 0) + ((we2 && a2 == r) ? 1 : 0);
                inc = ((rw1 && ra1 == r) ? 1 : 0) + ((rw2 && ra2 == r) ? 1 : 0);
                if (mfl_d && pend[r] == 0) w = 0;
                if (fl) begin
                    if (pend[r] < w) merr = 1'b1;
                    pend[r] = 0;
                end else begin
                    nv = pend[r] + inc - w;
                    if (nv < 0) begin merr = 1'b1; nv = 0; end
                    if (nv > 3) begin merr = 1'b1; nv = 3; end
                    pend[r] = nv;
                end
            end
            mfl_d = fl;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
